// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer
//   Byte-stream command front-end for the queue calculator. Each command byte
//   ({4'b0, operand_follows, op[2:0]}) plus its optional operand byte becomes
//   one calc_apply pulse. After a settle delay the calculator outputs are
//   captured and returned as one response word.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   s_valid/s_ready/s_data        command byte stream (valid/ready)
//   calc_in/calc_op/calc_apply    operand, opcode and one-cycle strobe to calculator
//   calc_tail/calc_empty/calc_valid  calculator status inputs
//   r_valid/r_ready/r_tail/r_flags   response word (valid/ready), flags =
//                                 {timeout, proto_err, calc_err, empty}
//   busy                          FSM not idle
//   err_count                     saturating count of responses with an error flag
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command byte
// OPND    | command wants an operand byte; timeout counter running
// ISSUE   | calc_apply high for this single cycle
// SETTLE  | waiting for calculator outputs to settle
// RESP    | response word presented until consumed

module calc_cmd_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int TIMEOUT       = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [7:0] s_data,
   output logic [7:0] calc_in,
   output logic [2:0] calc_op,
   output logic       calc_apply,
   input  logic [7:0] calc_tail,
   input  logic       calc_empty,
   input  logic       calc_valid,
   output logic       r_valid,
   input  logic       r_ready,
   output logic [7:0] r_tail,
   output logic [3:0] r_flags,
   output logic       busy,
   output logic [7:0] err_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_OPND, S_ISSUE, S_SETTLE, S_RESP
   } state_t;

   localparam bit          TMO_EN      = (TIMEOUT != 0);
   localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);
   localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES);

   state_t      state, state_nxt;
   logic [2:0]  op_q;
   logic [15:0] tmo_cnt;
   logic [7:0]  settle_cnt;

   logic        load_resp;
   logic [7:0]  tail_nxt;
   logic [3:0]  flags_nxt;

   always_comb begin
      state_nxt  = state;
      s_ready    = 1'b0;
      calc_apply = 1'b0;
      r_valid    = 1'b0;
      load_resp  = 1'b0;
      tail_nxt   = 8'h00;
      flags_nxt  = 4'b0000;
      case (state)
         S_IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               if (s_data[7:4] != 4'h0) begin
                  state_nxt = S_RESP;
                  load_resp = 1'b1;
                  flags_nxt = 4'b0100;
               end else if (s_data[3]) begin
                  state_nxt = S_OPND;
               end else begin
                  state_nxt = S_ISSUE;
               end
            end
         end
         S_OPND: begin
            s_ready = 1'b1;
            if (s_valid) begin
               state_nxt = S_ISSUE;
            end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
               // this idle cycle brings the count to TIMEOUT
               state_nxt = S_RESP;
               load_resp = 1'b1;
               flags_nxt = 4'b1000;
            end
         end
         S_ISSUE: begin
            calc_apply = 1'b1;
            state_nxt  = S_SETTLE;
         end
         S_SETTLE: begin
            // counter hits 0 on this edge: SETTLE lasts SETTLE_CYCLES cycles
            if (settle_cnt <= 8'd1) begin
               state_nxt = S_RESP;
               load_resp = 1'b1;
               tail_nxt  = calc_tail;
               flags_nxt = {2'b00, ~calc_valid, calc_empty};
            end
         end
         S_RESP: begin
            r_valid = 1'b1;
            if (r_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         op_q       <= 3'd0;
         tmo_cnt    <= 16'd0;
         settle_cnt <= 8'd0;
         calc_in    <= 8'h00;
         calc_op    <= 3'd0;
         r_tail     <= 8'h00;
         r_flags    <= 4'b0000;
         err_count  <= 8'h00;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (s_valid) begin
                  op_q    <= s_data[2:0];
                  tmo_cnt <= 16'd0;
                  if (s_data[7:3] == 5'b00000) begin
                     calc_in <= 8'h00;
                     calc_op <= s_data[2:0];
                  end
               end
            end
            S_OPND: begin
               if (s_valid) begin
                  calc_in <= s_data;
                  calc_op <= op_q;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            S_ISSUE:  settle_cnt <= SETTLE_LOAD;
            S_SETTLE: if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
            default: ;
         endcase
         if (load_resp) begin
            r_tail  <= tail_nxt;
            r_flags <= flags_nxt;
            if ((flags_nxt[3:1] != 3'b000) && (err_count != 8'hFF))
               err_count <= err_count + 8'd1;
         end
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
module tb_calc_cmd_sequencer;

   localparam int SETTLE = 2;
   localparam int TMO    = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] s_data = 8'h00;
   logic [7:0] calc_in;
   logic [2:0] calc_op;
   logic       calc_apply;
   logic [7:0] calc_tail = 8'h00;
   logic       calc_empty = 1'b0;
   logic       calc_valid = 1'b1;
   logic       r_valid;
   logic       r_ready = 1'b1;
   logic [7:0] r_tail;
   logic [3:0] r_flags;
   logic       busy;
   logic [7:0] err_count;

   always #5 clk = ~clk;

   calc_cmd_sequencer #(.SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .calc_in(calc_in), .calc_op(calc_op), .calc_apply(calc_apply),
      .calc_tail(calc_tail), .calc_empty(calc_empty), .calc_valid(calc_valid),
      .r_valid(r_valid), .r_ready(r_ready), .r_tail(r_tail), .r_flags(r_flags),
      .busy(busy), .err_count(err_count)
   );

   int checks   = 0;
   int failures = 0;
   int apply_cnt = 0;
   int cyc = 0;
   int last_apply_cyc = 0;
   int rise_cyc = 0;
   logic rv_prev = 1'b0;

   logic [10:0] exp_apply[$];   // {calc_in, calc_op}
   logic [12:0] exp_resp[$];    // {check_tail, tail, flags}

   // toy calculator: tail moves one cycle after each apply
   always @(posedge clk) if (calc_apply) calc_tail <= calc_in + 8'd1 + {5'd0, calc_op};
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      logic [10:0] e;
      if (calc_apply) begin
         apply_cnt++;
         last_apply_cyc = cyc;
         if (exp_apply.size() == 0) begin
            checks++; failures++;
            $display("FAIL apply_unexpected actual in=%0h op=%0h required none", calc_in, calc_op);
         end else begin
            e = exp_apply.pop_front();
            chk("apply_in", int'(calc_in), int'(e[10:3]));
            chk("apply_op", int'(calc_op), int'(e[2:0]));
         end
      end
   end

   always @(negedge clk) begin
      logic [12:0] e;
      if (r_valid && !rv_prev) rise_cyc = cyc;
      rv_prev = r_valid;
      if (r_valid && r_ready) begin
         if (exp_resp.size() == 0) begin
            checks++; failures++;
            $display("FAIL resp_unexpected actual tail=%0h flags=%0h required none", r_tail, r_flags);
         end else begin
            e = exp_resp.pop_front();
            chk("resp_flags", int'(r_flags), int'(e[3:0]));
            if (e[12]) chk("resp_tail", int'(r_tail), int'(e[11:4]));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit done = 0;
      s_valid = 1'b1;
      s_data  = b;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge clk);
         if (s_ready) begin
            @(posedge clk); #1;
            done = 1;
         end
      end
      s_valid = 1'b0;
      if (!done) chk("send_byte_accepted", 0, 1);
   endtask

   task automatic wait_idle(input string name);
      bit done = 0;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         if (!busy) done = 1;
      end
      if (!done) chk(name, 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_rvalid(input string name);
      bit done = 0;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         if (r_valid) done = 1;
      end
      if (!done) chk(name, 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int viol;
      logic [7:0] tail0;
      logic [3:0] flags0;
      bit seen;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_s_ready", int'(s_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_r_valid", int'(r_valid), 0);
      chk("rst_apply", int'(calc_apply), 0);
      chk("rst_calc_in", int'(calc_in), 0);
      chk("rst_calc_op", int'(calc_op), 0);
      chk("rst_r_tail", int'(r_tail), 0);
      chk("rst_r_flags", int'(r_flags), 0);
      chk("rst_err_count", int'(err_count), 0);
      @(posedge clk); #1;

      // T1: op 0 with operand 2A
      exp_apply.push_back({8'h2A, 3'd0});
      exp_resp.push_back({1'b1, 8'h2B, 4'b0000});
      send_byte(8'h08);
      send_byte(8'h2A);
      wait_idle("t1_idle");
      chk("t1_apply_cnt", apply_cnt, 1);
      chk("t1_calc_in_held", int'(calc_in), 'h2A);

      // T2: op 3 without operand, queue reports empty
      calc_empty = 1'b1;
      exp_apply.push_back({8'h00, 3'd3});
      exp_resp.push_back({1'b1, 8'h04, 4'b0001});
      send_byte(8'h03);
      wait_idle("t2_idle");
      calc_empty = 1'b0;
      chk("t2_latency", rise_cyc - last_apply_cyc, SETTLE + 1);
      chk("t2_calc_op_held", int'(calc_op), 3);
      chk("t2_calc_in_held", int'(calc_in), 0);

      // T3: reserved bits set
      exp_resp.push_back({1'b1, 8'h00, 4'b0100});
      send_byte(8'h93);
      wait_idle("t3_idle");
      chk("t3_err_count", int'(err_count), 1);
      chk("t3_apply_cnt", apply_cnt, 2);

      // T4: operand never arrives
      r_ready = 1'b0;
      exp_resp.push_back({1'b0, 8'h00, 4'b1000});
      send_byte(8'h09);
      n = 0;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (r_valid) seen = 1;
         else n++;
      end
      chk("t4_timeout_cycles", n, TMO);
      @(posedge clk); #1;
      r_ready = 1'b1;
      wait_idle("t4_idle");
      chk("t4_err_count", int'(err_count), 2);
      chk("t4_apply_cnt", apply_cnt, 2);
      chk("t4_busy", int'(busy), 0);

      // T5: back-pressure on the response, then the held byte is taken
      r_ready = 1'b0;
      exp_apply.push_back({8'h00, 3'd5});
      exp_resp.push_back({1'b1, 8'h06, 4'b0000});
      send_byte(8'h05);
      wait_rvalid("t5_rvalid");
      tail0  = r_tail;
      flags0 = r_flags;
      @(posedge clk); #1;
      exp_apply.push_back({8'h00, 3'd6});
      exp_resp.push_back({1'b1, 8'h07, 4'b0000});
      s_valid = 1'b1;
      s_data  = 8'h06;
      viol = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (s_ready !== 1'b0 || r_valid !== 1'b1 || r_tail !== tail0 || r_flags !== flags0) viol++;
      end
      chk("t5_hold_violations", viol, 0);
      chk("t5_apply_cnt", apply_cnt, 3);
      chk("t5_tail_held", int'(r_tail), 'h06);
      @(posedge clk); #1;
      r_ready = 1'b1;
      send_byte(8'h06);
      wait_idle("t5_idle");
      chk("t5_apply_cnt_after", apply_cnt, 4);

      // T6: reset in SETTLE, then a calculator error
      exp_apply.push_back({8'h00, 3'd2});
      send_byte(8'h02);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (calc_apply) seen = 1;
      end
      if (!seen) chk("t6_apply_seen", 0, 1);
      @(posedge clk); #1;
      chk("t6_busy_in_settle", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_r_valid", int'(r_valid), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_apply", int'(calc_apply), 0);
      chk("t6_rst_err_count", int'(err_count), 0);
      chk("t6_rst_s_ready", int'(s_ready), 1);
      @(posedge clk); #1;
      calc_valid = 1'b0;
      exp_apply.push_back({8'h00, 3'd1});
      exp_resp.push_back({1'b1, 8'h02, 4'b0010});
      send_byte(8'h01);
      wait_idle("t6_idle");
      calc_valid = 1'b1;
      chk("t6_err_count", int'(err_count), 1);

      repeat (3) @(posedge clk);
      chk("apply_total", apply_cnt, 6);
      chk("apply_q_left", exp_apply.size(), 0);
      chk("resp_q_left", exp_resp.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
